// File: rtl/multicycle_control_unit.sv
// Moore main controller for the multicycle MIPS datapath: sequences each
// instruction through fetch/decode/execute/memory/writeback with memory wait states.
module multicycle_control_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Instr,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             Branch,
  output logic             PCWrite,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic             PCEn,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEXE = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] instr_count_q, instr_count_d;
  logic [1:0]       alu_op;
  logic [5:0]       opcode, funct;
  logic             opcode_known;
  logic             retire;
  logic             instr_unused;

  assign opcode       = Instr[31:26];
  assign funct        = Instr[5:0];
  assign instr_unused = ^Instr;

  assign opcode_known = (opcode == OP_LW)   || (opcode == OP_SW)  ||
                        (opcode == OP_RTYP) || (opcode == OP_ADDI) ||
                        (opcode == OP_BEQ)  || (opcode == OP_J);

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    Branch   = 1'b0;
    PCWrite  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    alu_op   = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_RTEXE;
          OP_ADDI:      state_d = S_ADDIEXE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR, S_ADDIEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (state_q == S_ADDIEXE)  state_d = S_ADDIWB;
        else if (opcode == OP_LW)  state_d = S_MEMRD;
        else                       state_d = S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        // Held for the whole stall so the memory sees a stable write request.
        IorD     = 1'b1;
        MemWrite = 1'b1;
        mem_req  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTEXE: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ALUControl = 3'b010;
    case (alu_op)
      2'b00: ALUControl = 3'b010;
      2'b01: ALUControl = 3'b100;
      default: begin
        case (funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b100;
          6'b101010: ALUControl = 3'b110;
          6'b011100: ALUControl = 3'b101;
          default:   ALUControl = 3'b010;
        endcase
      end
    endcase
  end

  // An illegal opcode returns to FETCH from DECODE and never counts as retired.
  assign retire = (state_q == S_MEMWB)  || (state_q == S_ALUWB) ||
                  (state_q == S_ADDIWB) || (state_q == S_BRANCH) ||
                  (state_q == S_JUMP)   || ((state_q == S_MEMWR) && mem_ready);

  assign instr_count_d = retire ? instr_count_q + WIDTH'(1) : instr_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign illegal     = (state_q == S_DECODE) && !opcode_known;
  assign PCEn        = PCWrite | (Branch & Zero);
  assign state_o     = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: each task walks one instruction
// class cycle by cycle against hand-computed state, control and counter values.
module tb_multicycle_control_unit;

  logic        clk, rst, Zero, mem_ready;
  logic [31:0] Instr;
  logic        mem_req, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite;
  logic        ALUSrcA, Branch, PCWrite, PCEn, illegal;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  state_o;
  logic [31:0] instr_count;
  logic [15:0] ctrl;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_cnt = 0;

  multicycle_control_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .Branch(Branch), .PCWrite(PCWrite), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .PCEn(PCEn), .ALUControl(ALUControl), .illegal(illegal), .state_o(state_o),
    .instr_count(instr_count)
  );

  // Packed view of the 1/2-bit controls, MSB first:
  // mem_req IorD IRWrite MemWrite RegDst MemtoReg RegWrite ALUSrcA Branch PCWrite ALUSrcB PCSrc PCEn illegal
  assign ctrl = {mem_req, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite,
                 ALUSrcA, Branch, PCWrite, ALUSrcB, PCSrc, PCEn, illegal};

  localparam logic [15:0] C_FETCH   = 16'hA052;
  localparam logic [15:0] C_FETCH_W = 16'h8010;
  localparam logic [15:0] C_DECODE  = 16'h0030;
  localparam logic [15:0] C_DEC_ILL = 16'h0031;
  localparam logic [15:0] C_ADR     = 16'h0120;
  localparam logic [15:0] C_MEMRD   = 16'hC000;
  localparam logic [15:0] C_MEMWB   = 16'h0600;
  localparam logic [15:0] C_MEMWR   = 16'hD000;
  localparam logic [15:0] C_RTEXE   = 16'h0100;
  localparam logic [15:0] C_ALUWB   = 16'h0A00;
  localparam logic [15:0] C_ADDIWB  = 16'h0200;
  localparam logic [15:0] C_BR_Z    = 16'h0186;
  localparam logic [15:0] C_BR_NZ   = 16'h0184;
  localparam logic [15:0] C_JUMP    = 16'h004A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; Instr = 32'h0; Zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    vectors++; if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    vectors++; if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    vectors++; if (ctrl !== C_FETCH) begin errors++; $display("FAIL reset_ctrl_ready: got %h expected %h", ctrl, C_FETCH); end
    mem_ready = 1'b0; #1;
    vectors++; if (ctrl !== C_FETCH_W) begin errors++; $display("FAIL reset_ctrl_wait: got %h expected %h", ctrl, C_FETCH_W); end
    mem_ready = 1'b1; #1;
  endtask

  task automatic test_lw();
    logic [3:0]  st[6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [15:0] ct[6] = '{C_FETCH, C_DECODE, C_ADR, C_MEMRD, C_MEMWB, C_FETCH};
    Instr = 32'h8C22_0004; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vectors++; if (state_o !== st[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state_o, st[i]); end
      vectors++; if (ctrl !== ct[i]) begin errors++; $display("FAIL lw_ctrl[%0d]: got %h expected %h", i, ctrl, ct[i]); end
      if (i < 5) tick();
    end
    exp_cnt++;
    vectors++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL lw_count: got %0d expected %0d", instr_count, exp_cnt); end
  endtask

  task automatic test_rtype();
    logic [5:0] fn[5]  = '{6'h20, 6'h22, 6'h2A, 6'h1C, 6'h3F};
    logic [2:0] alu[5] = '{3'b010, 3'b100, 3'b110, 3'b101, 3'b010};
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      Instr = {6'b000000, 20'h22801, fn[k]};
      vectors++; if (ALUControl !== 3'b010) begin errors++; $display("FAIL rt_fetch_alu[%0d]: got %b expected 010", k, ALUControl); end
      tick();
      vectors++; if (state_o !== 4'd1) begin errors++; $display("FAIL rt_decode[%0d]: got %0d expected 1", k, state_o); end
      tick();
      vectors++; if (state_o !== 4'd6) begin errors++; $display("FAIL rt_exe_state[%0d]: got %0d expected 6", k, state_o); end
      vectors++; if (ALUControl !== alu[k]) begin errors++; $display("FAIL rt_alu[%0d]: got %b expected %b", k, ALUControl, alu[k]); end
      vectors++; if (ctrl !== C_RTEXE) begin errors++; $display("FAIL rt_exe_ctrl[%0d]: got %h expected %h", k, ctrl, C_RTEXE); end
      tick();
      vectors++; if (state_o !== 4'd7) begin errors++; $display("FAIL rt_wb_state[%0d]: got %0d expected 7", k, state_o); end
      vectors++; if (ctrl !== C_ALUWB) begin errors++; $display("FAIL rt_wb_ctrl[%0d]: got %h expected %h", k, ctrl, C_ALUWB); end
      tick();
      exp_cnt++;
      vectors++; if (state_o !== 4'd0) begin errors++; $display("FAIL rt_done[%0d]: got %0d expected 0", k, state_o); end
      vectors++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL rt_count[%0d]: got %0d expected %0d", k, instr_count, exp_cnt); end
    end
  endtask

  task automatic test_addi();
    logic [3:0]  st[5] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    logic [15:0] ct[5] = '{C_FETCH, C_DECODE, C_ADR, C_ADDIWB, C_FETCH};
    Instr = 32'h2002_0005; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (state_o !== st[i]) begin errors++; $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state_o, st[i]); end
      vectors++; if (ctrl !== ct[i]) begin errors++; $display("FAIL addi_ctrl[%0d]: got %h expected %h", i, ctrl, ct[i]); end
      if (i < 4) tick();
    end
    exp_cnt++;
    vectors++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL addi_count: got %0d expected %0d", instr_count, exp_cnt); end
  endtask

  task automatic test_beq();
    logic [15:0] cb;
    Instr = 32'h1022_0003; mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      Zero = z[0];
      cb = z[0] ? C_BR_Z : C_BR_NZ;
      tick(); tick();
      vectors++; if (state_o !== 4'd8) begin errors++; $display("FAIL beq_state[z=%0d]: got %0d expected 8", z, state_o); end
      vectors++; if (ctrl !== cb) begin errors++; $display("FAIL beq_ctrl[z=%0d]: got %h expected %h", z, ctrl, cb); end
      vectors++; if (ALUControl !== 3'b100) begin errors++; $display("FAIL beq_alu[z=%0d]: got %b expected 100", z, ALUControl); end
      tick();
      exp_cnt++;
      vectors++; if (state_o !== 4'd0) begin errors++; $display("FAIL beq_done[z=%0d]: got %0d expected 0", z, state_o); end
      vectors++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL beq_count[z=%0d]: got %0d expected %0d", z, instr_count, exp_cnt); end
    end
    Zero = 1'b0;
  endtask

  task automatic test_sw_stall();
    Instr = 32'hAC22_0004; mem_ready = 1'b1;
    tick(); tick();
    vectors++; if (state_o !== 4'd2) begin errors++; $display("FAIL sw_adr: got %0d expected 2", state_o); end
    tick();
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3); #1;
      vectors++; if (state_o !== 4'd5) begin errors++; $display("FAIL sw_wr_state[%0d]: got %0d expected 5", k, state_o); end
      vectors++; if (ctrl !== C_MEMWR) begin errors++; $display("FAIL sw_wr_ctrl[%0d]: got %h expected %h", k, ctrl, C_MEMWR); end
      vectors++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL sw_wr_count[%0d]: got %0d expected %0d", k, instr_count, exp_cnt); end
      tick();
    end
    exp_cnt++;
    vectors++; if (state_o !== 4'd0) begin errors++; $display("FAIL sw_done: got %0d expected 0", state_o); end
    vectors++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL sw_count: got %0d expected %0d", instr_count, exp_cnt); end
  endtask

  task automatic test_fetch_stall();
    Instr = 32'h8C22_0004; mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++; if (state_o !== 4'd0) begin errors++; $display("FAIL fstall_state[%0d]: got %0d expected 0", k, state_o); end
      vectors++; if (ctrl !== C_FETCH_W) begin errors++; $display("FAIL fstall_ctrl[%0d]: got %h expected %h", k, ctrl, C_FETCH_W); end
    end
    mem_ready = 1'b1; #1;
    vectors++; if (ctrl !== C_FETCH) begin errors++; $display("FAIL fstall_release: got %h expected %h", ctrl, C_FETCH); end
  endtask

  task automatic test_illegal();
    Instr = 32'hFC00_0000; mem_ready = 1'b1; #1;
    vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_fetch: got %b expected 0", illegal); end
    tick();
    vectors++; if (state_o !== 4'd1) begin errors++; $display("FAIL ill_decode: got %0d expected 1", state_o); end
    vectors++; if (ctrl !== C_DEC_ILL) begin errors++; $display("FAIL ill_ctrl: got %h expected %h", ctrl, C_DEC_ILL); end
    tick();
    vectors++; if (state_o !== 4'd0) begin errors++; $display("FAIL ill_return: got %0d expected 0", state_o); end
    vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_one_cycle: got %b expected 0", illegal); end
    vectors++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL ill_count: got %0d expected %0d", instr_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    Instr = 32'h8C22_0004; mem_ready = 1'b1;
    tick(); tick();
    vectors++; if (state_o !== 4'd2) begin errors++; $display("FAIL rmid_adr: got %0d expected 2", state_o); end
    rst = 1'b1;
    tick();
    vectors++; if (state_o !== 4'd0) begin errors++; $display("FAIL rmid_state: got %0d expected 0", state_o); end
    vectors++; if (instr_count !== 32'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", instr_count); end
    vectors++; if (ctrl !== C_FETCH) begin errors++; $display("FAIL rmid_ctrl: got %h expected %h", ctrl, C_FETCH); end
    rst = 1'b0;
    Instr = 32'h0800_0010;
    tick(); tick(); tick();
    vectors++; if (instr_count !== 32'd1) begin errors++; $display("FAIL rmid_j_count: got %0d expected 1", instr_count); end
    tick(); tick();
    vectors++; if (state_o !== 4'd11) begin errors++; $display("FAIL rmid_jump: got %0d expected 11", state_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (instr_count !== 32'd0) begin errors++; $display("FAIL rmid_retire_vs_reset: got %0d expected 0", instr_count); end
    vectors++; if (state_o !== 4'd0) begin errors++; $display("FAIL rmid_retire_state: got %0d expected 0", state_o); end
    exp_cnt = 0;
  endtask

  task automatic test_wrap();
    mem_ready = 1'b0; Instr = 32'h0800_0010;
    force dut.instr_count_d = 32'hFFFF_FFFF;
    tick();
    release dut.instr_count_d;
    #1;
    vectors++; if (instr_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffffffff", instr_count); end
    mem_ready = 1'b1;
    tick(); tick();
    vectors++; if (state_o !== 4'd11) begin errors++; $display("FAIL wrap_jump_state: got %0d expected 11", state_o); end
    vectors++; if (ctrl !== C_JUMP) begin errors++; $display("FAIL wrap_jump_ctrl: got %h expected %h", ctrl, C_JUMP); end
    tick();
    vectors++; if (instr_count !== 32'd0) begin errors++; $display("FAIL wrap_count: got %h expected 00000000", instr_count); end
    vectors++; if (state_o !== 4'd0) begin errors++; $display("FAIL wrap_done: got %0d expected 0", state_o); end
  endtask

  initial begin
    rst = 1'b1; Instr = 32'h0; Zero = 1'b0; mem_ready = 1'b1;
    test_reset();
    test_lw();
    test_rtype();
    test_addi();
    test_beq();
    test_sw_stall();
    test_fetch_stall();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style main controller for the multicycle MIPS datapath, successor to the single-cycle decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and supports the same instruction set: lw, sw, R-type (add, sub, slt, mul), addi, beq and j. It adds a memory ready handshake for wait states, illegal-opcode detection and a WIDTH-bit retired-instruction counter. It sits between the instruction register and the shared-memory multicycle datapath.

## Interface
- WIDTH, 32: instruction width and retired-counter width (≥32).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- Instr  in  WIDTH  instruction register contents; opcode = Instr[31:26], funct = Instr[5:0].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested (FETCH, MEMRD, MEMWR).
- IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite  out  1 each  datapath controls.
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- PCEn  out  1  PCWrite | (Branch & Zero).
- ALUControl  out  3  010 add, 100 sub, 110 slt, 101 mul.
- illegal  out  1  undefined opcode seen in DECODE.
- state_o  out  4  current state encoding (debug).
- instr_count  out  WIDTH  retired instructions.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXE 6, ALUWB 7, BRANCH 8, ADDIEXE 9, ADDIWB 10, JUMP 11. Codes 12–15 are unreachable and go to FETCH.
- Transitions:
  - FETCH→DECODE when mem_ready, else hold.
  - DECODE by opcode: 100011/101011→MEMADR; 000000→RTEXE; 001000→ADDIEXE; 000100→BRANCH; 000010→JUMP; any other→FETCH with illegal=1.
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB when mem_ready.
  - MEMWR→FETCH when mem_ready.
  - RTEXE→ALUWB; ADDIEXE→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP→FETCH.
- Outputs are decoded from state only. Every signal not listed for a state is 0.
  - FETCH: mem_req=1, ALUSrcB=01, IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcB=11.
  - MEMADR and ADDIEXE: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: IorD=1, mem_req=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1, mem_req=1. These stay high for the whole stall.
  - RTEXE: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - ADDIWB: RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
  - JUMP: PCSrc=10, PCWrite=1.
- ALUOp is internal. ALUOp 00→010 and 01→100. ALUOp 10 uses funct: 100000→010, 100010→100, 101010→110, 011100→101, any other funct→010. ALUControl is fully defined with no latches.
- illegal = (state==DECODE) & opcode undefined. It is combinational and lasts one cycle.
- instr_count increments by 1 on each retire transition: MEMWB, ALUWB, ADDIWB, BRANCH, JUMP→FETCH, and MEMWR→FETCH with mem_ready. An illegal return does not count.
- instr_count wraps from 2^WIDTH−1 to 0.

## Timing
- Reset edge: state=FETCH, instr_count=0.
- Outputs after reset are the FETCH decode: mem_req=1, ALUSrcB=01, IRWrite=PCWrite=PCEn=mem_ready, all others 0, illegal=0.
- Reset mid-instruction abandons it on that edge. No RegWrite or MemWrite follows, and the counter clears.
- Cycles with mem_ready=1 throughout: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle and holds all outputs. IRWrite and PCWrite stay 0 until mem_ready.
- A retire and a reset on the same edge: reset wins and the count is 0.

## Test plan
- Reset, then lw (0x8C220004) with mem_ready=1: state_o 0→1→2→3→4→0. RegWrite=1 and MemtoReg=1 only in state 4. instr_count=1 after 5 cycles.
- R-type sub, slt, mul and an undefined funct 0x3F: in RTEXE, ALUControl = 100, 110, 101, 010. Each instruction takes 4 cycles and ALUWB has RegDst=1.
- beq with Zero=1 then Zero=0: PCEn=1 only for Zero=1 in BRANCH, PCSrc=01. Both instructions retire after 3 cycles.
- sw with mem_ready held low for 3 cycles in MEMWR: MemWrite=1 for 4 cycles, instr_count increments once, total 7 cycles.
- Opcode 0x3F: illegal=1 for exactly one cycle in DECODE, return to FETCH, instr_count unchanged. Then rst asserted during MEMADR of an lw: next state FETCH, count 0.
- Preload instr_count near wrap (WIDTH=32, retire 2^32 instructions, or force the counter value) and retire j: count goes 0xFFFFFFFF→0, with PCWrite=1 and PCSrc=10 in JUMP.
